blink_rx: RTL and testbench
===========================

# blink_rx

Receive side of the single-wire blink signal driven on the F25-style GPIO. Samples an asynchronous input pin on the 48 MHz HFOSC clock, synchronizes and debounces it, emits edge strobes, and measures high time, low time and period of each complete blink cycle. Sits in the top level behind an input-configured SB_IO, so one board can check another board's blink rate or its own loopback.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flops in the input synchronizer (min 2).
- DEBOUNCE, 4: consecutive synchronized cycles of a new value required before `level` follows (min 1).
- CNT_W, 26: width of time counters; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock (HFOSC 48 MHz).
- rst_n  in  1  reset; asynchronous and active-low.
- pin_in  in  1  raw asynchronous pin value.
- level  out  1  debounced pin level.
- rise  out  1  one-cycle strobe when `level` goes 0→1.
- fall  out  1  one-cycle strobe when `level` goes 1→0.
- high_time  out  CNT_W  high duration of the last complete cycle, in clocks.
- low_time  out  CNT_W  low duration of the last complete cycle, in clocks.
- period  out  CNT_W+1  high_time + low_time of the last complete cycle.
- meas_valid  out  1  one-cycle strobe when high_time/low_time/period update.
- timeout  out  1  one-cycle strobe when a measurement is abandoned on counter saturation.

## Operation
- Reset (rst_n low, asynchronous): synchronizer chain, debounce count, `level`, all strobes, high_time, low_time, period and the counter `t` clear to 0. The FSM enters SEEK.
- Synchronizer: `s` is the output of SYNC_STAGES flip-flops on pin_in. Nothing else samples pin_in.
- Debounce:
  - When `s` equals `level`, the count clears to 0.
  - When `s` differs from `level`, the count increments.
  - When the count reaches DEBOUNCE-1 with `s` still differing, `level` takes `s` on the next edge and the count clears.
  - Glitches shorter than DEBOUNCE cycles never reach `level`.
- Strobes: `rise` and `fall` are registered. Each is high in the first cycle in which `level` shows its new value.
- FSM states: SEEK, HIGH, LOW.
  - SEEK: ignore `fall`. On `rise`, set t←1 and go to HIGH.
  - HIGH: t←sat(t+1) each cycle. On `fall`, set high_time←t and t←1, and go to LOW.
  - LOW: t←sat(t+1) each cycle. On `rise`:
    - Update low_time←t and period←high_time+t (zero-extended, no overflow).
    - Pulse meas_valid.
    - Set t←1 and go to HIGH.
  - HIGH or LOW, t reaches 2^CNT_W-1 with no edge: pulse timeout for one cycle and go to SEEK. Outputs keep their previous measurement.
  - high_time updates at `fall` and is visible before meas_valid. Consumers read all three outputs only at meas_valid.
- Saturation: t never wraps. The saturated value is never latched into high_time or low_time.
- Pin high at reset release: `level` starts at 0. After SYNC_STAGES+DEBOUNCE cycles a `rise` occurs and the FSM enters HIGH. This is the required behaviour.
- Reset mid-measurement discards the partial measurement. No meas_valid follows reset until a full rise→fall→rise sequence completes.

## Timing
- pin_in change to `level`/strobe: SYNC_STAGES+DEBOUNCE clocks, ±1 for pin_in asynchrony.
- meas_valid is asserted in the same cycle as `rise`. high_time/low_time/period hold their new values from that cycle onward.
- Measurement resolution is 1 clock. A stable signal with H high and L low clocks measures exactly high_time=H and low_time=L.
- Fastest measurable signal: H, L ≥ DEBOUNCE.
- Back-to-back cycles produce one meas_valid per rising edge, with no dead cycles.
- No output depends combinationally on pin_in.

## Test plan
- Reset/idle: hold rst_n low, toggle pin_in → all outputs 0. Release with pin_in=0 for 100 cycles → no strobes.
- Latency: default parameters, pin_in 0→1 at cycle 0 → `rise` at cycle 6±1 and `level`=1 thereafter. No meas_valid.
- Square wave: H=20, L=30 clocks, ≥3 periods → first meas_valid at the second rising `level` edge. high_time=20, low_time=30, period=50 at every meas_valid.
- Glitch rejection: 3-cycle high pulses on a low line (DEBOUNCE=4) → `level` stays 0, no rise/fall. A 4-cycle pulse → exactly one rise and one fall.
- Timeout: CNT_W=8, go high and hold 300 cycles → timeout pulses once when t hits 255, FSM returns to SEEK, prior measurement is unchanged. A following H=10/L=10 wave produces valid 10/10/20.
- Reset mid-op: assert rst_n during LOW of a 20/30 wave, then release → outputs 0. The first meas_valid comes only after a full new cycle, with the correct 20/30/50.

Source files
------------

// File: rtl/blink_rx.sv
// blink_rx: synchronizes and debounces an asynchronous blink input, emits
// edge strobes, and measures high time, low time and period of each
// complete blink cycle in clock ticks.
module blink_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pin_in,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             timeout
);

    localparam int               DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] T_MAX   = '1;
    localparam logic [CNT_W-1:0] T_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {SEEK, HIGH, LOW} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DB_W-1:0]        db_cnt;
    logic                   db_flip;
    logic                   rise_nxt;
    logic                   fall_nxt;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       t, t_nxt;
    logic [CNT_W-1:0]       high_time_nxt, low_time_nxt;
    logic [CNT_W:0]         period_nxt;
    logic                   meas_nxt, timeout_nxt;

    assign s = sync_q[SYNC_STAGES-1];

    // The level flips on the edge where the new value has been seen DEBOUNCE
    // times in a row; the strobes are derived from that same decision so they
    // appear in the first cycle that level shows its new value.
    assign db_flip  = (s != level) && (db_cnt == DB_LAST);
    assign rise_nxt = db_flip && s;
    assign fall_nxt = db_flip && !s;

    // Input synchronizer: the only place pin_in is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
        end
    end

    // Debounce counter, debounced level and registered edge strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= rise_nxt;
            fall <= fall_nxt;
            if (s == level) begin
                db_cnt <= '0;
            end else if (db_flip) begin
                level  <= s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Measurement FSM: next state, time counter and result registers. It acts
    // on the strobe decisions (not the registered strobes) so meas_valid lines
    // up with rise. Saturation is checked before edges so a saturated count is
    // never latched as a result.
    always_comb begin
        state_nxt     = state;
        t_nxt         = t;
        high_time_nxt = high_time;
        low_time_nxt  = low_time;
        period_nxt    = period;
        meas_nxt      = 1'b0;
        timeout_nxt   = 1'b0;
        case (state)
            SEEK: begin
                if (rise_nxt) begin
                    t_nxt     = T_ONE;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (t == T_MAX) begin
                    timeout_nxt = 1'b1;
                    t_nxt       = '0;
                    state_nxt   = SEEK;
                end else if (fall_nxt) begin
                    high_time_nxt = t;
                    t_nxt         = T_ONE;
                    state_nxt     = LOW;
                end else begin
                    t_nxt = t + 1'b1;
                end
            end
            LOW: begin
                if (t == T_MAX) begin
                    timeout_nxt = 1'b1;
                    t_nxt       = '0;
                    state_nxt   = SEEK;
                end else if (rise_nxt) begin
                    low_time_nxt = t;
                    period_nxt   = {1'b0, high_time} + {1'b0, t};
                    meas_nxt     = 1'b1;
                    t_nxt        = T_ONE;
                    state_nxt    = HIGH;
                end else begin
                    t_nxt = t + 1'b1;
                end
            end
            default: begin
                t_nxt     = '0;
                state_nxt = SEEK;
            end
        endcase
    end

    // Measurement FSM state, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEEK;
            t          <= '0;
            high_time  <= '0;
            low_time   <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            t          <= t_nxt;
            high_time  <= high_time_nxt;
            low_time   <= low_time_nxt;
            period     <= period_nxt;
            meas_valid <= meas_nxt;
            timeout    <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_blink_rx.sv
// tb_blink_rx: directed and randomized stimulus for blink_rx, with a
// segment-level model of the expected measurements.
module tb_blink_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pin_a, pin_b;

    logic        level_a, rise_a, fall_a, meas_a, tmo_a;
    logic [25:0] ht_a, lt_a;
    logic [26:0] per_a;

    logic        level_b, rise_b, fall_b, meas_b, tmo_b;
    logic [7:0]  ht_b, lt_b;
    logic [8:0]  per_b;

    int checks = 0;
    int errors = 0;

    // Model: the pin is driven as alternating constant segments. A
    // measurement is expected at every high segment that follows a complete
    // high+low pair seen since reset; its values are those segment lengths.
    bit have_h, have_l;
    int cur_h, cur_l;
    int exp_h[$];
    int exp_l[$];

    int cyc = 0;
    int n_rise_a = 0, n_fall_a = 0, n_meas_a = 0, n_tmo_a = 0;
    int n_meas_b = 0, n_tmo_b = 0;
    int last_rise_b = 0, tmo_dist = 0;

    blink_rx u_dut (
        .clk(clk), .rst_n(rst_n), .pin_in(pin_a),
        .level(level_a), .rise(rise_a), .fall(fall_a),
        .high_time(ht_a), .low_time(lt_a), .period(per_a),
        .meas_valid(meas_a), .timeout(tmo_a)
    );

    blink_rx #(.CNT_W(8)) u_tmo (
        .clk(clk), .rst_n(rst_n), .pin_in(pin_b),
        .level(level_b), .rise(rise_b), .fall(fall_b),
        .high_time(ht_b), .low_time(lt_b), .period(per_b),
        .meas_valid(meas_b), .timeout(tmo_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic observe();
        int eh, el;
        cyc++;
        if (rise_a) n_rise_a++;
        if (fall_a) n_fall_a++;
        if (tmo_a)  n_tmo_a++;
        if (meas_a) begin
            n_meas_a++;
            chk("meas_a_expected", 64'(exp_h.size() > 0), 64'd1);
            if (exp_h.size() > 0) begin
                eh = exp_h.pop_front();
                el = exp_l.pop_front();
                chk("high_time", 64'(ht_a), 64'(eh));
                chk("low_time", 64'(lt_a), 64'(el));
                chk("period", 64'(per_a), 64'(eh + el));
            end
        end
        if (rise_b) last_rise_b = cyc;
        if (tmo_b) begin
            n_tmo_b++;
            tmo_dist = cyc - last_rise_b;
        end
        if (meas_b) begin
            n_meas_b++;
            chk("b_high_time", 64'(ht_b), 64'd10);
            chk("b_low_time", 64'(lt_b), 64'd10);
            chk("b_period", 64'(per_b), 64'd20);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        observe();
    endtask

    task automatic model_clear();
        have_h = 0;
        have_l = 0;
        exp_h.delete();
        exp_l.delete();
    endtask

    task automatic seg(input bit val, input int n);
        if (val) begin
            if (have_h && have_l) begin
                exp_h.push_back(cur_h);
                exp_l.push_back(cur_l);
            end
            have_h = 1;
            have_l = 0;
            cur_h  = n;
        end else if (have_h) begin
            have_l = 1;
            cur_l  = n;
        end
        pin_a = val;
        repeat (n) tick();
    endtask

    task automatic segb(input bit val, input int n);
        pin_b = val;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        pin_a = 1'b0;
        pin_b = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        int lat, r0, f0, m0, h, l;
        rst_n = 1'b0;
        pin_a = 1'b0;
        pin_b = 1'b0;
        model_clear();

        // Reset/idle: pin toggles under reset, everything stays zero.
        for (int i = 0; i < 8; i++) begin
            pin_a = i[0];
            pin_b = ~i[0];
            tick();
        end
        chk("reset_strobes_a", 64'({level_a, rise_a, fall_a, meas_a, tmo_a}), 64'd0);
        chk("reset_times_a", 64'(ht_a) | 64'(lt_a) | 64'(per_a), 64'd0);
        chk("reset_strobes_b", 64'({level_b, rise_b, fall_b, meas_b, tmo_b}), 64'd0);
        pin_a = 1'b0;
        pin_b = 1'b0;
        rst_n = 1'b1;
        seg(0, 100);
        chk("idle_edges", 64'(n_rise_a + n_fall_a), 64'd0);
        chk("idle_meas", 64'(n_meas_a + n_tmo_a), 64'd0);

        // Latency of a clean 0->1 step.
        pin_a = 1'b1;
        lat = -1;
        m0 = n_meas_a;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (rise_a && lat < 0) lat = i;
        end
        chk_range("rise_latency", lat, 5, 7);
        chk("latency_level", 64'(level_a), 64'd1);
        chk("latency_no_meas", 64'(n_meas_a - m0), 64'd0);

        // Square wave 20/30.
        do_reset();
        seg(0, 10);
        m0 = n_meas_a;
        for (int i = 0; i < 4; i++) begin
            seg(1, 20);
            seg(0, 30);
        end
        seg(1, 20);
        seg(0, 20);
        chk("square_meas_count", 64'(n_meas_a - m0), 64'd4);

        // Reset in the middle of a low phase.
        seg(1, 20);
        seg(0, 15);
        rst_n = 1'b0;
        #1;
        chk("midreset_times", 64'(ht_a) | 64'(lt_a) | 64'(per_a), 64'd0);
        chk("midreset_level", 64'({level_a, meas_a}), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        model_clear();
        m0 = n_meas_a;
        seg(0, 10);
        seg(1, 20);
        seg(0, 30);
        chk("midreset_no_early_meas", 64'(n_meas_a - m0), 64'd0);
        seg(1, 20);
        seg(0, 30);
        chk("midreset_meas_count", 64'(n_meas_a - m0), 64'd1);

        // Glitch rejection: 3-cycle pulses never reach level.
        do_reset();
        seg(0, 10);
        r0 = n_rise_a;
        f0 = n_fall_a;
        for (int i = 0; i < 3; i++) begin
            pin_a = 1'b1;
            repeat (3) tick();
            pin_a = 1'b0;
            repeat (10) tick();
        end
        chk("glitch_level", 64'(level_a), 64'd0);
        chk("glitch_edges", 64'((n_rise_a - r0) + (n_fall_a - f0)), 64'd0);
        seg(1, 4);
        seg(0, 20);
        chk("pulse4_rise", 64'(n_rise_a - r0), 64'd1);
        chk("pulse4_fall", 64'(n_fall_a - f0), 64'd1);

        // Randomized waves down to the fastest measurable timing.
        do_reset();
        seg(0, 10);
        for (int i = 0; i < 10; i++) begin
            h = $urandom_range(60, 4);
            l = $urandom_range(60, 4);
            seg(1, h);
            seg(0, l);
        end
        seg(1, 20);
        seg(0, 20);
        chk("model_queue_drained", 64'(exp_h.size()), 64'd0);
        chk("no_timeout_a", 64'(n_tmo_a), 64'd0);

        // Timeout on the 8-bit counter instance.
        do_reset();
        segb(0, 10);
        segb(1, 300);
        chk("tmo_count_1", 64'(n_tmo_b), 64'd1);
        chk_range("tmo_distance_1", tmo_dist, 254, 255);
        chk("tmo_no_meas", 64'(n_meas_b), 64'd0);
        chk("tmo_level", 64'(level_b), 64'd1);
        segb(0, 10);
        for (int i = 0; i < 3; i++) begin
            segb(1, 10);
            segb(0, 10);
        end
        chk("tmo_wave_meas", 64'(n_meas_b), 64'd2);
        segb(1, 300);
        chk("tmo_count_2", 64'(n_tmo_b), 64'd2);
        chk_range("tmo_distance_2", tmo_dist, 254, 255);
        chk("tmo_final_meas", 64'(n_meas_b), 64'd3);
        chk("tmo_hold_high", 64'(ht_b), 64'd10);
        chk("tmo_hold_low", 64'(lt_b), 64'd10);
        chk("tmo_hold_period", 64'(per_b), 64'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
